// File: rtl/dff_response_checker.sv
// dff_response_checker
//   Watches the D input and Q output of a W-bit D flip-flop stage and checks
//   that Q on every cycle equals what the flop should have captured on the
//   previous cycle. The expected value follows a synchronous active-high reset
//   flop model: it is zero while dut_reset is high, otherwise it is d_obs.
//   The checker counts compares and mismatches. Both counters saturate rather
//   than wrap. It reports pass/fail when the run ends.
//   Optional feature: define FIRST_FAIL_LOG_EN to add ff_valid/ff_index/
//   ff_exp/ff_got. These capture the first mismatch of each run.
module dff_response_checker #(
  parameter int W           = 4,
  parameter int MAX_SAMPLES = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dut_reset,
  input  logic [W-1:0]     d_obs,
  input  logic [W-1:0]     q_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_flag,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef FIRST_FAIL_LOG_EN
  ,
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_index,
  output logic [W-1:0]     ff_exp,
  output logic [W-1:0]     ff_got
`endif
);

  // The run length is tracked separately from sample_cnt. This lets auto-stop
  // still fire when sample_cnt has saturated before MAX_SAMPLES is reached.
  localparam int                RUN_W    = $clog2(MAX_SAMPLES + 1);
  localparam logic [RUN_W-1:0]  LAST_RUN = RUN_W'(MAX_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     expVal_q, expVal_d;
  logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic [RUN_W-1:0] runCnt_q, runCnt_d;
  logic             errFlag_q, errFlag_d;
  logic             pass_q, pass_d;
  logic             mismatch;
  logic             startRun;

  assign startRun = start && ((state_q == IDLE) || (state_q == DONE));

  // Use an if/else here rather than a plain !=. In simulation, an unknown
  // q_obs then falls into the mismatch branch. Synthesis still sees a plain
  // inequality.
  always_comb begin
    mismatch = 1'b1;
    if (q_obs == expVal_q) begin
      mismatch = 1'b0;
    end
  end

  // Next-state logic: run control, expectation tracking and saturating counters.
  always_comb begin
    state_d     = state_q;
    expVal_d    = expVal_q;
    sampleCnt_d = sampleCnt_q;
    errCnt_d    = errCnt_q;
    runCnt_d    = runCnt_q;
    errFlag_d   = errFlag_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = PRIME;
          sampleCnt_d = '0;
          errCnt_d    = '0;
          runCnt_d    = '0;
          errFlag_d   = 1'b0;
          pass_d      = 1'b0;
        end
      end
      PRIME: begin
        expVal_d = dut_reset ? '0 : d_obs;
        if (stop) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        expVal_d = dut_reset ? '0 : d_obs;
        runCnt_d = runCnt_q + 1'b1;
        if (sampleCnt_q != CNT_MAX) begin
          sampleCnt_d = sampleCnt_q + 1'b1;
        end
        if (mismatch) begin
          errFlag_d = 1'b1;
          if (errCnt_q != CNT_MAX) begin
            errCnt_d = errCnt_q + 1'b1;
          end
        end
        if (stop || (runCnt_q == LAST_RUN)) begin
          state_d = DONE;
          pass_d  = (errCnt_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      expVal_q    <= '0;
      sampleCnt_q <= '0;
      errCnt_q    <= '0;
      runCnt_q    <= '0;
      errFlag_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      expVal_q    <= expVal_d;
      sampleCnt_q <= sampleCnt_d;
      errCnt_q    <= errCnt_d;
      runCnt_q    <= runCnt_d;
      errFlag_q   <= errFlag_d;
      pass_q      <= pass_d;
    end
  end

  assign busy       = (state_q == PRIME) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_flag   = errFlag_q;
  assign sample_cnt = sampleCnt_q;
  assign err_cnt    = errCnt_q;

`ifdef FIRST_FAIL_LOG_EN
  logic             ffValid_q, ffValid_d;
  logic [CNT_W-1:0] ffIndex_q, ffIndex_d;
  logic [W-1:0]     ffExp_q, ffExp_d;
  logic [W-1:0]     ffGot_q, ffGot_d;

  // Capture the first mismatch of a run. A new run clears the capture.
  always_comb begin
    ffValid_d = ffValid_q;
    ffIndex_d = ffIndex_q;
    ffExp_d   = ffExp_q;
    ffGot_d   = ffGot_q;
    if (startRun) begin
      ffValid_d = 1'b0;
      ffIndex_d = '0;
      ffExp_d   = '0;
      ffGot_d   = '0;
    end else if ((state_q == CHECK) && mismatch && !ffValid_q) begin
      ffValid_d = 1'b1;
      ffIndex_d = sampleCnt_q;
      ffExp_d   = expVal_q;
      ffGot_d   = q_obs;
    end
  end

  // First-fail log registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ffValid_q <= 1'b0;
      ffIndex_q <= '0;
      ffExp_q   <= '0;
      ffGot_q   <= '0;
    end else begin
      ffValid_q <= ffValid_d;
      ffIndex_q <= ffIndex_d;
      ffExp_q   <= ffExp_d;
      ffGot_q   <= ffGot_d;
    end
  end

  assign ff_valid = ffValid_q;
  assign ff_index = ffIndex_q;
  assign ff_exp   = ffExp_q;
  assign ff_got   = ffGot_q;
`endif

endmodule

// File: tb/tb_dff_response_checker.sv
// tb_dff_response_checker
//   Builds a real flop in the bench, with an optional override on its Q, and
//   observes it with the checker. Expected results come from a per-run model.
//   The model counts compares and mismatches as plain integers. It clamps each
//   count to the counter range. It finishes the run on stop or after MAXS
//   compares.
module tb_dff_response_checker;

  localparam int W    = 4;
  localparam int MAXS = 40;
  localparam int CW   = 5;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dutRst = 1'b0;
  logic [W-1:0]  dIn = '0;
  logic [W-1:0]  dffQ = '0;
  logic          forceEn = 1'b0;
  logic [W-1:0]  forceVal = '0;
  logic [W-1:0]  qObs;
  logic          busy, done, pass, errFlag;
  logic [CW-1:0] sampleCnt, errCnt;
`ifdef FIRST_FAIL_LOG_EN
  logic          ffValid;
  logic [CW-1:0] ffIndex;
  logic [W-1:0]  ffExp, ffGot;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state: 0 idle, 1 prime, 2 check, 3 done.
  int           mPhase = 0;
  int           mComp = 0;
  int           mErrRaw = 0;
  int           mSamp = 0;
  int           mErr = 0;
  bit           mFlag = 0;
  bit           mPass = 0;
  logic [W-1:0] mExp = '0;
  bit           mFfValid = 0;
  int           mFfIdx = 0;
  logic [W-1:0] mFfExp = '0;
  logic [W-1:0] mFfGot = '0;

  dff_response_checker #(.W(W), .MAX_SAMPLES(MAXS), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .dut_reset  (dutRst),
    .d_obs      (dIn),
    .q_obs      (qObs),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_flag   (errFlag),
    .sample_cnt (sampleCnt),
    .err_cnt    (errCnt)
`ifdef FIRST_FAIL_LOG_EN
    ,
    .ff_valid   (ffValid),
    .ff_index   (ffIndex),
    .ff_exp     (ffExp),
    .ff_got     (ffGot)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // The observed register: a sync active-high reset D flop.
  always @(posedge clk) dffQ <= dutRst ? '0 : dIn;

  assign qObs = forceEn ? forceVal : dffQ;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".busy"}, busy, (mPhase == 1 || mPhase == 2));
    checkOutput({tag, ".done"}, done, (mPhase == 3));
    checkOutput({tag, ".pass"}, pass, mPass);
    checkOutput({tag, ".err_flag"}, errFlag, mFlag);
    checkOutput({tag, ".sample_cnt"}, sampleCnt, mSamp);
    checkOutput({tag, ".err_cnt"}, errCnt, mErr);
`ifdef FIRST_FAIL_LOG_EN
    checkOutput({tag, ".ff_valid"}, ffValid, mFfValid);
    checkOutput({tag, ".ff_index"}, ffIndex, mFfIdx);
    checkOutput({tag, ".ff_exp"}, ffExp, mFfExp);
    checkOutput({tag, ".ff_got"}, ffGot, mFfGot);
`endif
  endtask

  // Drive one clock of inputs, advance the model over the same edge, then check.
  task automatic applyStimulus(input string tag, input logic [W-1:0] d, input bit rst,
                               input bit stp, input bit strt, input bit fEn,
                               input logic [W-1:0] fVal);
    logic [W-1:0] qSeen;
    bit mis;
    dIn = d;
    dutRst = rst;
    stop = stp;
    start = strt;
    forceEn = fEn;
    forceVal = fVal;
    qSeen = fEn ? fVal : dffQ;
    case (mPhase)
      1: begin
        mExp = rst ? '0 : d;
        if (stp) begin
          mPhase = 3;
          mPass = 1;
        end else begin
          mPhase = 2;
        end
      end
      2: begin
        mis = (qSeen !== mExp);
        if (mis && !mFfValid) begin
          mFfValid = 1;
          mFfIdx = mSamp;
          mFfExp = mExp;
          mFfGot = qSeen;
        end
        mComp++;
        mSamp = (mComp > SAT) ? SAT : mComp;
        if (mis) begin
          mErrRaw++;
          mErr = (mErrRaw > SAT) ? SAT : mErrRaw;
          mFlag = 1;
        end
        mExp = rst ? '0 : d;
        if (stp || mComp == MAXS) begin
          mPhase = 3;
          mPass = (mErrRaw == 0);
        end
      end
      default: begin
        if (strt) begin
          mPhase = 1;
          mComp = 0;
          mErrRaw = 0;
          mSamp = 0;
          mErr = 0;
          mFlag = 0;
          mPass = 0;
          mFfValid = 0;
          mFfIdx = 0;
          mFfExp = '0;
          mFfGot = '0;
        end
      end
    endcase
    tick();
    stop = 1'b0;
    start = 1'b0;
    forceEn = 1'b0;
    checkAll(tag);
  endtask

  task automatic doReset(input int cycles, input bit withStart);
    reset = 1'b1;
    start = withStart;
    stop = withStart;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    mPhase = 0;
    mComp = 0;
    mErrRaw = 0;
    mSamp = 0;
    mErr = 0;
    mFlag = 0;
    mPass = 0;
    mExp = '0;
    mFfValid = 0;
    mFfIdx = 0;
    mFfExp = '0;
    mFfGot = '0;
    checkAll("reset");
  endtask

  initial begin : mainSeq
    logic [W-1:0] pat [5];
    pat[0] = 4'b0000;
    pat[1] = 4'b0001;
    pat[2] = 4'b1110;
    pat[3] = 4'b1111;
    pat[4] = 4'b0110;

    $display("[TB] reset");
    doReset(5, 1'b0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sample_cnt", sampleCnt, 0);

    $display("[TB] clean run");
    applyStimulus("clean_start", pat[0], 0, 0, 1, 0, '0);
    applyStimulus("clean_prime", pat[0], 0, 0, 0, 0, '0);
    for (int j = 1; j <= 25; j++)
      applyStimulus("clean", pat[(j < 25 ? j : 24) / 5], 0, (j == 25), 0, 0, '0);
    checkOutput("clean_done", done, 1);
    checkOutput("clean_pass", pass, 1);
    checkOutput("clean_samples", sampleCnt, 25);
    checkOutput("clean_errs", errCnt, 0);
    applyStimulus("clean_hold", 4'b1010, 0, 0, 0, 0, '0);

    $display("[TB] dut reset");
    applyStimulus("drst_start", 4'b0101, 1, 0, 1, 0, '0);
    applyStimulus("drst_prime", 4'b0101, 1, 0, 0, 0, '0);
    for (int j = 0; j < 4; j++) applyStimulus("drst_ok", 4'b0101, 1, 0, 0, 0, '0);
    for (int j = 0; j < 3; j++) applyStimulus("drst_bad", 4'b0101, 1, (j == 2), 0, 1, 4'b0101);
    checkOutput("drst_errs", errCnt, 3);
    checkOutput("drst_pass", pass, 0);
    checkOutput("drst_flag", errFlag, 1);

    $display("[TB] single fault");
    applyStimulus("fault_start", 4'b1110, 0, 0, 1, 0, '0);
    applyStimulus("fault_prime", 4'b1110, 0, 0, 0, 0, '0);
    for (int j = 0; j < 12; j++)
      applyStimulus("fault", 4'b1110, 0, (j == 11), 0, (j == 7), 4'b1111);
    checkOutput("fault_errs", errCnt, 1);
`ifdef FIRST_FAIL_LOG_EN
    checkOutput("fault_ff_index", ffIndex, 7);
    checkOutput("fault_ff_exp", ffExp, 4'b1110);
    checkOutput("fault_ff_got", ffGot, 4'b1111);
`endif

    $display("[TB] stop in prime");
    applyStimulus("vac_start", 4'b0011, 0, 0, 1, 0, '0);
    applyStimulus("vac_prime", 4'b0011, 0, 1, 0, 0, '0);
    checkOutput("vac_pass", pass, 1);
    checkOutput("vac_samples", sampleCnt, 0);

    $display("[TB] auto-stop with saturation");
    applyStimulus("sat_start", $urandom, 0, 0, 1, 0, '0);
    applyStimulus("sat_prime", $urandom, 0, 0, 0, 0, '0);
    for (int j = 0; j < MAXS + 10; j++) begin
      if (mPhase == 3) break;
      applyStimulus("sat", $urandom, 0, 0, 0, 1, ~mExp);
    end
    checkOutput("sat_done", done, 1);
    checkOutput("sat_samples", sampleCnt, SAT);
    checkOutput("sat_errs", errCnt, SAT);
    for (int j = 0; j < 3; j++) applyStimulus("sat_hold", $urandom, $urandom_range(0, 1), 0, 0, 0, '0);

    $display("[TB] mid-run reset then restart");
    applyStimulus("mid_start", 4'b1001, 0, 0, 1, 0, '0);
    applyStimulus("mid_prime", 4'b1001, 0, 0, 0, 0, '0);
    for (int j = 0; j < 3; j++) applyStimulus("mid", $urandom, 0, 0, 0, 0, '0);
    doReset(1, 1'b1);
    applyStimulus("mid_restart", 4'b0111, 0, 0, 1, 0, '0);
    applyStimulus("mid_prime2", 4'b0111, 0, 0, 0, 0, '0);
    applyStimulus("mid_first", 4'b0111, 0, 0, 0, 0, '0);
    checkOutput("mid_first_sample", sampleCnt, 1);

    $display("[TB] random runs");
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < MAXS + 5; j++) begin
        if (mPhase == 3) break;
        applyStimulus("rand", $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                      $urandom_range(0, 1), ($urandom_range(0, 5) == 0), $urandom);
      end
      applyStimulus("rand_hold", $urandom, 0, 0, 0, 0, '0);
      applyStimulus("rand_start", $urandom, 0, 0, 1, 0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
